// File: rtl/md_sched_if.sv
// Handshake and result bundle between the E/D pipeline stages and the
// multiply/divide scheduler.
interface md_sched_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, md_use_d,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, md_use_d,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler and HI/LO owner for the MIPS pipeline.
// Fixed-latency ops are timed by a 4-bit down-counter; results land on its last tick.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no op in flight; accepts mult/div, applies mthi/mtlo now
//   ST_RUN  | op in flight; r_cnt counts remaining busy cycles
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [2:0]  r_op,    w_op_nxt;
    logic [31:0] r_a,     w_a_nxt;
    logic [31:0] r_b,     w_b_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;

    logic        w_busy;
    logic        w_long_issue;

    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;

    // Results depend only on the latched operands, never on the live bus.
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_neg_a    = (r_op == OP_DIV) & r_a[31];
    assign w_neg_b    = (r_op == OP_DIV) & r_b[31];
    assign w_mag_a    = w_neg_a ? -r_a : r_a;
    assign w_mag_b    = w_neg_b ? -r_b : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_den      = w_div_zero ? 32'd1 : w_mag_b;
    assign w_quo_u    = w_mag_a / w_den;
    assign w_rem_u    = w_mag_a % w_den;
    assign w_quo      = (w_neg_a ^ w_neg_b) ? -w_quo_u : w_quo_u;
    assign w_rem      = w_neg_a ? -w_rem_u : w_rem_u;

    assign w_busy       = (r_state == ST_RUN);
    assign w_long_issue = md.start & (md.md_op >= OP_MULT) & (md.md_op <= OP_DIVU);

    assign md.busy  = w_busy;
    assign md.stall = md.md_use_d & (w_busy | w_long_issue);
    assign md.hi    = r_hi;
    assign md.lo    = r_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        case (r_state)
            ST_IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        OP_MULT, OP_MULTU: begin
                            w_op_nxt    = md.md_op;
                            w_a_nxt     = md.a;
                            w_b_nxt     = md.b;
                            w_cnt_nxt   = MULT_CNT;
                            w_state_nxt = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_op_nxt    = md.md_op;
                            w_a_nxt     = md.a;
                            w_b_nxt     = md.b;
                            w_cnt_nxt   = DIV_CNT;
                            w_state_nxt = ST_RUN;
                        end
                        OP_MTHI: w_hi_nxt = md.a;
                        OP_MTLO: w_lo_nxt = md.a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (r_cnt > 4'd1) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                    case (r_op)
                        OP_MULT: begin
                            w_hi_nxt = w_prod_s[63:32];
                            w_lo_nxt = w_prod_s[31:0];
                        end
                        OP_MULTU: begin
                            w_hi_nxt = w_prod_u[63:32];
                            w_lo_nxt = w_prod_u[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (!w_div_zero) begin
                                w_hi_nxt = w_rem;
                                w_lo_nxt = w_quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares on each busy falling edge.
module tb_md_sched;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];
    int   run_len;
    logic prev_busy;

    md_sched_if u_if ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.cycles = cycles;
        sb.push_back(e);
    endtask

    // Drives start for one edge from the current point; stall is checked while start is up.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic exp_stall);
        u_if.start = 1'b1;
        u_if.md_op = op;
        u_if.a     = va;
        u_if.b     = vb;
        #1;
        chk("stall_issue", {31'd0, u_if.stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.md_op = 3'd0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!u_if.busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done: busy still 1 after 40 cycles at %0t", $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (u_if.busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: completion with empty scoreboard at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_hi", u_if.hi, e.hi);
                    chk("sb_lo", u_if.lo, e.lo);
                    chk("sb_busy_len", 32'(run_len), 32'(e.cycles));
                end
                run_len = 0;
            end
            prev_busy = u_if.busy;
        end
    end

    initial begin
        checks        = 0;
        failures      = 0;
        run_len       = 0;
        prev_busy     = 1'b0;
        reset         = 1'b1;
        u_if.start    = 1'b0;
        u_if.md_op    = 3'd0;
        u_if.a        = 32'd0;
        u_if.b        = 32'd0;
        u_if.md_use_d = 1'b1;

        #12;
        chk("rst_busy",  {31'd0, u_if.busy},  32'd0);
        chk("rst_stall", {31'd0, u_if.stall}, 32'd0);
        chk("rst_hi",    u_if.hi, 32'd0);
        chk("rst_lo",    u_if.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        u_if.md_use_d = 1'b0;
        @(negedge clk);

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        push(32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_done();

        // mult -1 * 2 = -2; operands cleared during RUN must not matter
        push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        u_if.a = 32'd0;
        u_if.b = 32'd0;
        wait_done();

        // div -7 / 2 = -3 rem -1, with an MD op waiting in D
        u_if.md_use_d = 1'b1;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_run_d", {31'd0, u_if.stall}, 32'd1);
        end
        @(negedge clk);
        chk("stall_idle_d", {31'd0, u_if.stall}, 32'd0);
        chk("busy_idle_d",  {31'd0, u_if.busy},  32'd0);
        u_if.md_use_d = 1'b0;

        // divu 7 / 2 = 3 rem 1
        push(32'd1, 32'd3, 10);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b0);
        wait_done();

        // divide by zero keeps HI/LO, full latency, no stall with empty D
        push(32'd1, 32'd3, 10);
        issue(OP_DIV, 32'd1234, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_run_nod", {31'd0, u_if.stall}, 32'd0);
        end
        wait_done();

        // signed overflow case
        push(32'd0, 32'h8000_0000, 10);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done();

        // mthi then mtlo on consecutive edges
        u_if.start = 1'b1;
        u_if.md_op = OP_MTHI;
        u_if.a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("mthi_hi",   u_if.hi, 32'h1234_5678);
        chk("mthi_busy", {31'd0, u_if.busy}, 32'd0);
        u_if.md_op = OP_MTLO;
        u_if.a     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        u_if.md_op = 3'd0;
        chk("mtlo_lo",   u_if.lo, 32'h9ABC_DEF0);
        chk("mtlo_hi",   u_if.hi, 32'h1234_5678);
        chk("mtlo_busy", {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);

        // mult 3 * -4 = -12 overwrites the moved values
        push(32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
        issue(OP_MULT, 32'd3, 32'hFFFF_FFFC, 1'b0);
        chk("mult_hold_hi", u_if.hi, 32'h1234_5678);
        wait_done();

        // back-to-back: each issue is sampled on the edge right after RUN ends
        push(32'd1, 32'd0, 5);
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_done();
        push(32'd2, 32'd14, 10);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        chk("b2b_busy", {31'd0, u_if.busy}, 32'd1);
        wait_done();

        // async reset during the third cycle of a mult
        issue(OP_MULT, 32'd5, 32'd6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, u_if.busy}, 32'd0);
        chk("arst_hi",   u_if.hi, 32'd0);
        chk("arst_lo",   u_if.lo, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        push(32'd0, 32'd15, 5);
        issue(OP_MULTU, 32'd3, 32'd5, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
